// File: rtl/dsram_responder.sv
// dsram_responder: data SRAM responder for the MEM stage.
// Accepts one read or byte-masked write at a time, inserts wait states while
// holding the requester via stall, then completes against an internal word
// array and presents a one-cycle response.
// Optional feature macro: DSRAM_LFSR_WAIT_EN (per-request wait count 0..3
// drawn from an 8-bit LFSR instead of WAIT_CYCLES).
module dsram_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        stall
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [3:0]            we_q, we_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic [31:0]           mem_q [DEPTH];

    logic                  accept;
    logic                  commit;
    logic [7:0]            wait_cnt;
    logic [3:0]            acc_we;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_wdata;

    // Byte-offset and out-of-range address bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

    assign accept = (state_q == S_IDLE) && req_en;

    // Access completes on the edge entering RESP: straight from IDLE when
    // there are no wait states, otherwise on the last WAIT cycle.
    assign commit = (accept && (wait_cnt == 8'd0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 8'd1));

`ifdef DSRAM_LFSR_WAIT_EN
    localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR (taps 8,6,5,4), stepped once per accepted request.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // LFSR state register, seeded on reset.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end

    assign wait_cnt = {6'd0, lfsr_q[1:0]};
`else
    assign wait_cnt = 8'(WAIT_CYCLES);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; RESP always returns to IDLE so req_en held
    // during RESP is not taken as a new request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_en) state_d = (wait_cnt == 8'd0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == 8'd1) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: stall the requester until its response cycle.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = ((state_q == S_IDLE) && req_en) || (state_q == S_WAIT);
        end
    end

    // Request latch, wait counter and response generation.
    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        if (accept) begin
            cnt_d   = wait_cnt;
            we_d    = req_we;
            idx_d   = req_addr[ADDR_WIDTH+1:2];
            wdata_d = req_wdata;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 8'd1;
        end

        // Zero-wait accesses complete before the latch is loaded.
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_idx   = req_addr[ADDR_WIDTH+1:2];
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
        end

        resp_valid_d = commit;
        resp_rdata_d = 32'd0;
        if (commit && (acc_we == 4'b0000)) begin
            resp_rdata_d = mem_q[acc_idx];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 8'd0;
            we_q         <= 4'd0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Word array, not reset; reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (commit && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_we[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Testbench for dsram_responder: four instances with wait counts 1, 0, 255
// and 3, a vector table on the W=1 instance plus hand-written sequences for
// zero/max wait, back-to-back throughput and reset during WAIT.
`timescale 1ns/1ps
module tb_dsram_responder;
    localparam int unsigned W_P [4] = '{1, 0, 255, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic        req_en     [4];
    logic [3:0]  req_we     [4];
    logic [31:0] req_addr   [4];
    logic [31:0] req_wdata  [4];
    logic        resp_valid [4];
    logic [31:0] resp_rdata [4];
    logic        stall      [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] lfsr_m [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .req_en(req_en[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .stall(stall[0]));
    dsram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req_en(req_en[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .stall(stall[1]));
    dsram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(255)) u_w255 (
        .clk(clk), .reset(reset), .req_en(req_en[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .stall(stall[2]));
    dsram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .req_en(req_en[3]), .req_we(req_we[3]),
        .req_addr(req_addr[3]), .req_wdata(req_wdata[3]),
        .resp_valid(resp_valid[3]), .resp_rdata(resp_rdata[3]), .stall(stall[3]));

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          gap;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected wait count for the next request on instance i.
    task automatic next_wait(input int i, output int unsigned w);
`ifdef DSRAM_LFSR_WAIT_EN
        w = 32'(lfsr_m[i][1:0]);
        lfsr_m[i] = {lfsr_m[i][6:0], lfsr_m[i][7] ^ lfsr_m[i][5] ^ lfsr_m[i][4] ^ lfsr_m[i][3]};
`else
        w = W_P[i];
`endif
    endtask

    task automatic reset_models();
        for (int k = 0; k < 4; k++) lfsr_m[k] = 8'hA5;
    endtask

    // One request from cycle T through its RESP cycle T+1+W.
    task automatic do_access(input int i, input logic [3:0] we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd,
                             input string name, output int unsigned w,
                             output int t0, output int t1);
        int stall_hi;
        int valid_hi;
        int valid_at;
        logic [31:0] rd;
        next_wait(i, w);
        @(posedge clk); #1;
        req_en[i] = 1'b1; req_we[i] = we; req_addr[i] = addr; req_wdata[i] = wdata;
        t0 = cyc;
        stall_hi = 0; valid_hi = 0; valid_at = -1; rd = 32'd0;
        for (int c = 0; c <= int'(w) + 1; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (stall[i] === 1'b1) stall_hi++;
            if (resp_valid[i] === 1'b1) begin
                valid_hi++; valid_at = c; rd = resp_rdata[i];
            end
        end
        t1 = cyc;
        chk({name, "_stall_cycles"}, 32'(stall_hi), 32'(w + 1));
        chk({name, "_stall_resp"}, 32'(stall[i]), 32'd0);
        chk({name, "_valid_count"}, 32'(valid_hi), 32'd1);
        chk({name, "_valid_cycle"}, 32'(valid_at), 32'(w + 1));
        chk({name, "_rdata"}, rd, exp_rd);
    endtask

    task automatic idle(input int i, input int n, input string name);
        @(posedge clk); #1;
        req_en[i] = 1'b0; req_we[i] = 4'd0;
        @(negedge clk);
        chk({name, "_idle_valid"}, 32'(resp_valid[i]), 32'd0);
        chk({name, "_idle_stall"}, 32'(stall[i]), 32'd0);
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) req_en[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        reset_models();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        int t0, t1, first_t0, sum_w, vcnt;
        int unsigned wc;

        tbl[0]  = '{4'hF, 32'h1c000010, 32'hDEADBEEF, 32'h0,        0};
        tbl[1]  = '{4'h0, 32'h1c000010, 32'h0,        32'hDEADBEEF, 1};
        tbl[2]  = '{4'hF, 32'h00000020, 32'h11223344, 32'h0,        0};
        tbl[3]  = '{4'h5, 32'h00000020, 32'hAABBCCDD, 32'h0,        0};
        tbl[4]  = '{4'h0, 32'h00000020, 32'h0,        32'h11BB33DD, 2};
        tbl[5]  = '{4'h3, 32'h00000020, 32'hFFFFFFFF, 32'h0,        0};
        tbl[6]  = '{4'h0, 32'h12340023, 32'h0,        32'h11BBFFFF, 0};
        tbl[7]  = '{4'h8, 32'h1c000010, 32'h5555AAAA, 32'h0,        1};
        tbl[8]  = '{4'h0, 32'h1c000010, 32'h0,        32'h55ADBEEF, 0};
        tbl[9]  = '{4'hF, 32'h00003FFC, 32'h01020304, 32'h0,        0};
        tbl[10] = '{4'hF, 32'h00000000, 32'hA5A5A5A5, 32'h0,        0};
        tbl[11] = '{4'h0, 32'h00004000, 32'h0,        32'hA5A5A5A5, 0};
        tbl[12] = '{4'h0, 32'h00003FFF, 32'h0,        32'h01020304, 0};
        tbl[13] = '{4'h0, 32'h00000020, 32'h0,        32'h11BBFFFF, 1};

        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_en[k] = 1'b0; req_we[k] = 4'd0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
        end
        reset_models();

        // Reset state, and stall held low under reset even with req_en high.
        repeat (3) @(posedge clk);
        #1 req_en[0] = 1'b1;
        @(negedge clk);
        chk("reset_stall_req", 32'(stall[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_valid_%0d", k), 32'(resp_valid[k]), 32'd0);
            chk($sformatf("reset_rdata_%0d", k), resp_rdata[k], 32'd0);
        end
        @(posedge clk); #1;
        req_en[0] = 1'b0;
        reset = 1'b0;
        reset_models();
        @(negedge clk);
        chk("post_reset_stall", 32'(stall[0]), 32'd0);

        // Vector table on the W=1 instance.
        for (int v = 0; v < 14; v++) begin
            do_access(0, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].exp_rd,
                      $sformatf("v%0d", v), w, t0, t1);
            if (tbl[v].gap > 0) idle(0, tbl[v].gap, $sformatf("v%0d", v));
        end

        // Eight back-to-back reads right after reset; total time = sum(W+2).
        do_reset();
        sum_w = 0;
        first_t0 = 0;
        for (int r = 0; r < 8; r++) begin
            case (r % 4)
                0: do_access(0, 4'h0, 32'h00000020, 32'h0, 32'h11BBFFFF, $sformatf("b2b%0d", r), w, t0, t1);
                1: do_access(0, 4'h0, 32'h1c000010, 32'h0, 32'h55ADBEEF, $sformatf("b2b%0d", r), w, t0, t1);
                2: do_access(0, 4'h0, 32'h00003FFC, 32'h0, 32'h01020304, $sformatf("b2b%0d", r), w, t0, t1);
                default: do_access(0, 4'h0, 32'h00000000, 32'h0, 32'hA5A5A5A5, $sformatf("b2b%0d", r), w, t0, t1);
            endcase
            if (r == 0) first_t0 = t0;
            sum_w = sum_w + int'(w) + 2;
        end
        chk("b2b_total_cycles", 32'(t1 - first_t0 + 1), 32'(sum_w));
        idle(0, 1, "b2b");

        // Zero wait: stall at T only, response at T+1, next request at T+2.
        do_access(1, 4'hF, 32'h00000080, 32'h0BADF00D, 32'h0, "w0_wr", w, t0, t1);
        do_access(1, 4'h0, 32'h00000080, 32'h0,        32'h0BADF00D, "w0_rd", w, t0, t1);
        do_access(1, 4'h2, 32'h00000080, 32'h0000EE00, 32'h0, "w0_wrm", w, t0, t1);
        do_access(1, 4'h0, 32'h00000080, 32'h0,        32'h0BADEE0D, "w0_rdm", w, t0, t1);
        idle(1, 1, "w0");

        // Maximum wait: 256 stall cycles and one pulse at T+256.
        do_access(2, 4'hF, 32'h00000100, 32'h12345678, 32'h0, "w255_wr", w, t0, t1);
        idle(2, 1, "w255_wr");
        do_access(2, 4'h0, 32'h00000100, 32'h0, 32'h12345678, "w255_rd", w, t0, t1);
        idle(2, 1, "w255_rd");

        // Reset during WAIT discards the pending write.
        do_access(3, 4'hF, 32'h00000040, 32'h01010101, 32'h0, "w3_pre", w, t0, t1);
        idle(3, 1, "w3_pre");
        next_wait(3, wc);
        vcnt = 0;
        @(posedge clk); #1;
        req_en[3] = 1'b1; req_we[3] = 4'hF; req_addr[3] = 32'h00000040; req_wdata[3] = 32'hCAFEF00D;
        @(negedge clk);
        if (resp_valid[3] === 1'b1) vcnt++;
        @(posedge clk); #1;
        @(negedge clk);
        if (resp_valid[3] === 1'b1) vcnt++;
        @(posedge clk); #1;
        reset = 1'b1;
        req_en[3] = 1'b0;
        @(negedge clk);
        if (resp_valid[3] === 1'b1) vcnt++;
        chk("rst_wait_stall", 32'(stall[3]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        reset_models();
        @(negedge clk);
        chk("rst_after_valid", 32'(resp_valid[3]), 32'd0);
        chk("rst_after_stall", 32'(stall[3]), 32'd0);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid[3] === 1'b1) vcnt++;
        end
        chk("rst_valid_pulses", 32'(vcnt), (wc < 2) ? 32'd1 : 32'd0);
        do_access(3, 4'h0, 32'h00000040, 32'h0,
                  (wc < 2) ? 32'hCAFEF00D : 32'h01010101, "w3_post", w, t0, t1);
        idle(3, 1, "w3_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
